// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: instruction fetch vs data, data-priority with starvation bound.
// Optional LL/SC link tracking is enabled with `define ATOMIC_LINK_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        datomic,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [1:0] ACCESS = 2'd2;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  logic dreq;
  logic ram_acc;
  logic sc;
  logic sc_fail;

  assign dreq    = dREN | dWEN;
  assign ram_acc = (ramstate == ACCESS);

`ifdef ATOMIC_LINK_EN
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        ll;
  logic        link_hit;

  assign sc       = dWEN & datomic;
  assign ll       = dREN & datomic & ~dWEN;
  assign link_hit = link_valid_q && (link_addr_q == daddr);
  // An SC without a live matching link completes at once, untouched RAM
  assign sc_fail  = sc & ~link_hit;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (dhit) begin
      if (ll) begin
        link_valid_d = 1'b1;
        link_addr_d  = daddr;
      end else if (sc && link_hit) begin
        link_valid_d = 1'b0;
      end else if (dWEN && !datomic && daddr == link_addr_q) begin
        link_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`else
  logic unused_datomic;

  assign unused_datomic = datomic;
  assign sc             = 1'b0;
  assign sc_fail        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && (!iREN || starve_q < SMAX)) begin
          state_d = SERVE_D;
          if (iREN && starve_q < SMAX) starve_d = starve_q + 4'd1;
        end else if (iREN) begin
          state_d  = SERVE_I;
          starve_d = '0;
        end
      end
      SERVE_I: begin
        if (!iREN)        state_d = IDLE;
        else if (ram_acc) state_d = DONE;
      end
      SERVE_D: begin
        if (!dreq)                   state_d = IDLE;
        else if (sc_fail || ram_acc) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      SERVE_I: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_acc) begin
            ihit  = 1'b1;
            iload = ramload;
          end
        end
      end
      SERVE_D: begin
        if (dreq) begin
          if (sc_fail) begin
            dhit = 1'b1;
          end else if (dWEN) begin
            ramWEN   = 1'b1;
            ramaddr  = daddr;
            ramstore = dstore;
            if (ram_acc) begin
              dhit  = 1'b1;
              dload = {31'b0, sc};
            end
          end else begin
            ramREN  = 1'b1;
            ramaddr = daddr;
            if (ram_acc) begin
              dhit  = 1'b1;
              dload = ramload;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule
